iterative_shifter: RTL and testbench

//  Multi-cycle parametrised shifter for MIPS shift instructions: logical left, logical right and arithmetic right.

---
 rtl/iterative_shifter_if.sv | 25 ++
 rtl/iterative_shifter.sv | 120 ++++++++++++
 tb/tb_iterative_shifter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/iterative_shifter_if.sv
// Request/result bundle for iterative_shifter.
// The master starts a shift (start_i, mode_i, shamt_i, data_i) and watches busy_o,
// done_o and data_o. The slave is the shifter itself.
interface iterative_shifter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
);
    logic                  start_i;
    logic [1:0]            mode_i;
    logic [SHAMT_W-1:0]    shamt_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] data_o;

    modport master (
        output start_i, mode_i, shamt_i, data_i,
        input  busy_o, done_o, data_o
    );

    modport slave (
        input  start_i, mode_i, shamt_i, data_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle MIPS shifter: SLL, SRL, SRA, and optionally ROR.
// The shifter moves at most STEP bits per clock and reports through a start/busy/done handshake.
// Build option: define SHIFTER_ROTATE_EN to make mode 2'b11 a rotate right.
// Without it, mode 2'b11 decodes as SRL and no rotate logic is built.
module iterative_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    iterative_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // The remaining count never exceeds DATA_WIDTH-1.
    // Capping STEP at that value keeps the step amount within SHAMT_W bits.
    localparam int                 STEP_CAP = (STEP > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : STEP;
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP_CAP);

    // One step of the selected shift. SRA fills with the current MSB.
    // That bit is the operand MSB, because SRA never changes the MSB.
    function automatic logic [DATA_WIDTH-1:0] shift_step(
        input logic [DATA_WIDTH-1:0] w,
        input logic [1:0]            mode,
        input logic [SHAMT_W-1:0]    s
    );
        logic signed [DATA_WIDTH-1:0] ws;
        logic [DATA_WIDTH-1:0]        res;
`ifdef SHIFTER_ROTATE_EN
        logic [SHAMT_W:0]             back;
`endif
        ws  = w;
        res = w >> s;
        case (mode)
            MODE_SLL: res = w << s;
            MODE_SRA: res = ws >>> s;
`ifdef SHIFTER_ROTATE_EN
            MODE_ROR: begin
                // With s==0, back equals DATA_WIDTH and the left term becomes zero.
                back = (SHAMT_W + 1)'(DATA_WIDTH) - {1'b0, s};
                res  = (w >> s) | (w << back);
            end
`endif
            default:  res = w >> s;
        endcase
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q;
    logic [1:0]            mode_q;
    logic [SHAMT_W-1:0]    rem_q;
    logic                  busy_q, done_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic [SHAMT_W-1:0]    step_amt;
    logic [SHAMT_W-1:0]    rem_next;
    logic [DATA_WIDTH-1:0] step_data;

    // Step size, remaining count after this step, and the shifted work value.
    always_comb begin
        step_amt  = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
        rem_next  = rem_q - step_amt;
        step_data = shift_step(work_q, mode_q, step_amt);
    end

    // Next-state decode. Start is honoured only in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = SHIFT;
            SHIFT:   if (rem_next == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, the sampled request, and the registered outputs. Reset aborts at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            case (state_q)
                IDLE: if (bus.start_i) begin
                    mode_q <= bus.mode_i;
                    rem_q  <= bus.shamt_i;
                end
                SHIFT: begin
                    rem_q <= rem_next;
                    if (rem_next == '0) data_q <= step_data;
                end
                default: ;
            endcase
        end
    end

    // Working operand. It is loaded on accept and shifted on each SHIFT cycle. It has no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start_i) work_q <= bus.data_i;
        else if (state_q == SHIFT)         work_q <= step_data;
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.data_o = data_q;
endmodule

// File: tb/tb_iterative_shifter.sv
// Directed-vector bench for iterative_shifter with hand-computed expected values.
// The main instance uses STEP=4. Two side instances use STEP=1 and STEP=32.
module tb_iterative_shifter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    iterative_shifter_if #(.DATA_WIDTH(32)) bus   ();
    iterative_shifter_if #(.DATA_WIDTH(32)) bus1  ();
    iterative_shifter_if #(.DATA_WIDTH(32)) bus32 ();

    iterative_shifter #(.DATA_WIDTH(32), .STEP(4))  dut     (.clk(clk), .reset(reset), .bus(bus.slave));
    iterative_shifter #(.DATA_WIDTH(32), .STEP(1))  dut_s1  (.clk(clk), .reset(reset), .bus(bus1.slave));
    iterative_shifter #(.DATA_WIDTH(32), .STEP(32)) dut_s32 (.clk(clk), .reset(reset), .bus(bus32.slave));

    // Compare one observed value with its expected value and record the result.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one request on the STEP=4 instance.
    // Checks the SHIFT-cycle count, the result, a one-cycle done pulse and the return to idle.
    task automatic run_op(input string tag, input logic [1:0] mode, input logic [4:0] shamt,
                          input logic [31:0] data, input logic [31:0] exp_data, input int exp_n);
        int   n;
        logic seen;
        @(negedge clk);
        bus.mode_i = mode; bus.shamt_i = shamt; bus.data_i = data; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.mode_i = ~mode; bus.shamt_i = ~shamt; bus.data_i = ~data;
        check({tag, " busy_after_accept"}, 32'(bus.busy_o), 32'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            seen = bus.done_o;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_n));
        check({tag, " data"}, bus.data_o, exp_data);
        check({tag, " busy_in_done"}, 32'(bus.busy_o), 32'd1);
        @(posedge clk); #1;
        check({tag, " done_width"}, 32'(bus.done_o), 32'd0);
        check({tag, " busy_idle"}, 32'(bus.busy_o), 32'd0);
        check({tag, " data_hold"}, bus.data_o, exp_data);
    endtask

    initial begin
        int   n, n1, n32;
        logic seen;
        bus.start_i = 0;   bus.mode_i = 0;   bus.shamt_i = 0;   bus.data_i = 0;
        bus1.start_i = 0;  bus1.mode_i = 0;  bus1.shamt_i = 0;  bus1.data_i = 0;
        bus32.start_i = 0; bus32.mode_i = 0; bus32.shamt_i = 0; bus32.data_i = 0;

        // Reset state
        #12;
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset data", bus.data_o, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Basic operations
        run_op("srl_16_2",    2'b01, 5'd2,  32'h0000_0010, 32'h0000_0004, 1);
        run_op("sra_max",     2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 8);
        run_op("sll_max",     2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 8);
        run_op("sll_zero",    2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        run_op("sra_neg_9",   2'b10, 5'd9,  32'hF000_00F0, 32'hFFF8_0000, 3);
        run_op("sra_pos_5",   2'b10, 5'd5,  32'h7000_0000, 32'h0380_0000, 2);
        run_op("srl_neg_8",   2'b01, 5'd8,  32'hF000_0000, 32'h00F0_0000, 2);
`ifdef SHIFTER_ROTATE_EN
        run_op("mode11",      2'b11, 5'd4,  32'h0000_00F1, 32'h1000_000F, 1);
`else
        run_op("mode11",      2'b11, 5'd4,  32'h0000_00F1, 32'h0000_000F, 1);
`endif

        // Starts during SHIFT and DONE are ignored
        @(negedge clk);
        bus.mode_i = 2'b00; bus.shamt_i = 5'd31; bus.data_i = 32'hFFFF_FFFF; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            bus.start_i = (n == 2); bus.mode_i = 2'b01; bus.shamt_i = 5'd1; bus.data_i = 32'h1234_5678;
            @(posedge clk); #1;
            n++;
            seen = bus.done_o;
        end
        check("ignore latency", 32'(n), 32'd8);
        check("ignore data", bus.data_o, 32'h8000_0000);
        @(negedge clk); bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        check("done_start busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        check("done_start not_queued", 32'(bus.busy_o), 32'd0);
        check("done_start data", bus.data_o, 32'h8000_0000);

        // Reset in the third SHIFT cycle aborts the operation
        @(negedge clk);
        bus.mode_i = 2'b00; bus.shamt_i = 5'd31; bus.data_i = 32'hFFFF_FFFF; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy_o), 32'd0);
        check("abort done", 32'(bus.done_o), 32'd0);
        check("abort data", bus.data_o, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b1;
            @(posedge clk); #1;
            if (bus.done_o) seen = 1'b1;
        end
        check("abort no_done", 32'(seen), 32'd0);
        check("abort idle", 32'(bus.busy_o), 32'd0);
        run_op("after_reset", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 8);

        // STEP=1 and STEP=32 instances
        @(negedge clk);
        bus1.mode_i  = 2'b01; bus1.shamt_i  = 5'd31; bus1.data_i  = 32'hFFFF_FFFF; bus1.start_i  = 1'b1;
        bus32.mode_i = 2'b01; bus32.shamt_i = 5'd31; bus32.data_i = 32'hFFFF_FFFF; bus32.start_i = 1'b1;
        @(posedge clk); #1;
        bus1.start_i = 1'b0; bus32.start_i = 1'b0;
        n1 = -1; n32 = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus1.done_o && n1 < 0)   n1 = i;
            if (bus32.done_o && n32 < 0) n32 = i;
        end
        check("step1 latency", 32'(n1), 32'd31);
        check("step1 data", bus1.data_o, 32'h0000_0001);
        check("step32 latency", 32'(n32), 32'd1);
        check("step32 data", bus32.data_o, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
